// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU to memory AXI-lite arbiter.
// The FSM state encoding and the bus-owner encoding live here.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RSP,
    WR_REQ,
    WR_RSP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    IFU,
    LSU
  } owner_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bit positions of each master in the request/grant vectors.
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/axi_lite_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker plus the register holding the last granted master.
// On a tie the master that was not granted last wins.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  owner_t r_last_grant;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[GNT_LSU] && (!i_req[GNT_IFU] || (r_last_grant == IFU))) begin
      o_gnt[GNT_LSU] = 1'b1;
    end else if (i_req[GNT_IFU]) begin
      o_gnt[GNT_IFU] = 1'b1;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IFU;
    end else if (i_take && (o_gnt != 2'b00)) begin
      r_last_grant <= o_gnt[GNT_LSU] ? LSU : IFU;
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite memory slave between the IFU (read-only) and the LSU
// (read/write). One whole transaction is granted at a time.
module axi_lite_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read channels
  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  input  logic                i_ifu_arvalid,
  output logic                o_ifu_arready,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  output logic                o_ifu_rvalid,
  input  logic                i_ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  input  logic                i_lsu_arvalid,
  output logic                o_lsu_arready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  output logic                o_lsu_rvalid,
  input  logic                i_lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  input  logic                i_lsu_awvalid,
  output logic                o_lsu_awready,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic                i_lsu_wvalid,
  output logic                o_lsu_wready,
  output logic [1:0]          o_lsu_bresp,
  output logic                o_lsu_bvalid,
  input  logic                i_lsu_bready,
  // Slave read channels
  output logic [ADDR_W-1:0]   o_slv_araddr,
  output logic                o_slv_arvalid,
  input  logic                i_slv_arready,
  input  logic [DATA_W-1:0]   i_slv_rdata,
  input  logic [1:0]          i_slv_rresp,
  input  logic                i_slv_rvalid,
  output logic                o_slv_rready,
  // Slave write channels
  output logic [ADDR_W-1:0]   o_slv_awaddr,
  output logic                o_slv_awvalid,
  input  logic                i_slv_awready,
  output logic [DATA_W-1:0]   o_slv_wdata,
  output logic [DATA_W/8-1:0] o_slv_wstrb,
  output logic                o_slv_wvalid,
  input  logic                i_slv_wready,
  input  logic [1:0]          i_slv_bresp,
  input  logic                i_slv_bvalid,
  output logic                o_slv_bready
);

  state_t r_state;
  owner_t r_owner;
  logic   r_aw_done;
  logic   r_w_done;

  state_t w_state_nxt;
  owner_t w_owner_nxt;
  logic   w_aw_done_nxt;
  logic   w_w_done_nxt;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_take;
  logic              w_lsu_wr;
  logic              w_own_lsu;
  logic [ADDR_W-1:0] w_sel_araddr;
  logic              w_sel_arvalid;
  logic              w_sel_rready;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_all;
  logic              w_w_all;

  assign w_lsu_wr        = i_lsu_awvalid & i_lsu_wvalid;
  assign w_req[GNT_LSU]  = i_lsu_arvalid | w_lsu_wr;
  assign w_req[GNT_IFU]  = i_ifu_arvalid;
  assign w_take          = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .i_req  (w_req),
    .i_take (w_take),
    .o_gnt  (w_gnt)
  );

  // Channel selection follows the registered owner, never the live requests.
  assign w_own_lsu     = (r_owner == LSU);
  assign w_sel_araddr  = w_own_lsu ? i_lsu_araddr  : i_ifu_araddr;
  assign w_sel_arvalid = w_own_lsu ? i_lsu_arvalid : i_ifu_arvalid;
  assign w_sel_rready  = w_own_lsu ? i_lsu_rready  : i_ifu_rready;

  assign w_aw_hs  = (r_state == WR_REQ) & i_lsu_awvalid & i_slv_awready & ~r_aw_done;
  assign w_w_hs   = (r_state == WR_REQ) & i_lsu_wvalid  & i_slv_wready  & ~r_w_done;
  assign w_aw_all = r_aw_done | w_aw_hs;
  assign w_w_all  = r_w_done  | w_w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= NONE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;

    o_ifu_arready = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = RESP_OKAY;
    o_ifu_rvalid  = 1'b0;
    o_lsu_arready = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = RESP_OKAY;
    o_lsu_rvalid  = 1'b0;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bresp   = RESP_OKAY;
    o_lsu_bvalid  = 1'b0;
    o_slv_araddr  = '0;
    o_slv_arvalid = 1'b0;
    o_slv_rready  = 1'b0;
    o_slv_awaddr  = '0;
    o_slv_awvalid = 1'b0;
    o_slv_wdata   = '0;
    o_slv_wstrb   = '0;
    o_slv_wvalid  = 1'b0;
    o_slv_bready  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_owner_nxt = NONE;
        if (w_gnt[GNT_LSU]) begin
          w_owner_nxt = LSU;
          // A write outranks a simultaneous read from the same master.
          w_state_nxt = w_lsu_wr ? WR_REQ : RD_REQ;
        end else if (w_gnt[GNT_IFU]) begin
          w_owner_nxt = IFU;
          w_state_nxt = RD_REQ;
        end
      end

      RD_REQ: begin
        o_slv_araddr  = w_sel_araddr;
        o_slv_arvalid = w_sel_arvalid;
        if (w_own_lsu) o_lsu_arready = i_slv_arready;
        else           o_ifu_arready = i_slv_arready;
        if (w_sel_arvalid && i_slv_arready) w_state_nxt = RD_RSP;
      end

      RD_RSP: begin
        o_slv_rready = w_sel_rready;
        if (w_own_lsu) begin
          o_lsu_rdata  = i_slv_rdata;
          o_lsu_rresp  = i_slv_rresp;
          o_lsu_rvalid = i_slv_rvalid;
        end else begin
          o_ifu_rdata  = i_slv_rdata;
          o_ifu_rresp  = i_slv_rresp;
          o_ifu_rvalid = i_slv_rvalid;
        end
        if (i_slv_rvalid && w_sel_rready) begin
          w_state_nxt = IDLE;
          w_owner_nxt = NONE;
        end
      end

      WR_REQ: begin
        o_slv_awaddr  = i_lsu_awaddr;
        o_slv_awvalid = i_lsu_awvalid & ~r_aw_done;
        o_lsu_awready = i_slv_awready & ~r_aw_done;
        o_slv_wdata   = i_lsu_wdata;
        o_slv_wstrb   = i_lsu_wstrb;
        o_slv_wvalid  = i_lsu_wvalid & ~r_w_done;
        o_lsu_wready  = i_slv_wready & ~r_w_done;
        if (w_aw_all && w_w_all) begin
          w_state_nxt   = WR_RSP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = w_aw_all;
          w_w_done_nxt  = w_w_all;
        end
      end

      WR_RSP: begin
        o_lsu_bresp  = i_slv_bresp;
        o_lsu_bvalid = i_slv_bvalid;
        o_slv_bready = i_lsu_bready;
        if (i_slv_bvalid && i_lsu_bready) begin
          w_state_nxt = IDLE;
          w_owner_nxt = NONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_owner_nxt = NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scoreboard bench for axi_lite_mem_arbiter: directed master/slave stimulus pushes
// expected responses; a monitor pops and compares on every R/B handshake.
module tb_axi_lite_mem_arbiter;

  localparam int BUDGET     = 200;
  localparam int CH_IFU_AR  = 0;
  localparam int CH_LSU_AR  = 1;
  localparam int CH_LSU_AW  = 2;
  localparam int CH_LSU_W   = 3;
  localparam int SRC_IFU_R  = 0;
  localparam int SRC_LSU_R  = 1;
  localparam int SRC_LSU_B  = 2;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        clk, rst;
  logic [31:0] i_ifu_araddr;  logic i_ifu_arvalid; logic o_ifu_arready;
  logic [31:0] o_ifu_rdata;   logic [1:0] o_ifu_rresp; logic o_ifu_rvalid; logic i_ifu_rready;
  logic [31:0] i_lsu_araddr;  logic i_lsu_arvalid; logic o_lsu_arready;
  logic [31:0] o_lsu_rdata;   logic [1:0] o_lsu_rresp; logic o_lsu_rvalid; logic i_lsu_rready;
  logic [31:0] i_lsu_awaddr;  logic i_lsu_awvalid; logic o_lsu_awready;
  logic [31:0] i_lsu_wdata;   logic [3:0] i_lsu_wstrb; logic i_lsu_wvalid; logic o_lsu_wready;
  logic [1:0]  o_lsu_bresp;   logic o_lsu_bvalid;  logic i_lsu_bready;
  logic [31:0] o_slv_araddr;  logic o_slv_arvalid; logic i_slv_arready;
  logic [31:0] i_slv_rdata;   logic [1:0] i_slv_rresp; logic i_slv_rvalid; logic o_slv_rready;
  logic [31:0] o_slv_awaddr;  logic o_slv_awvalid; logic i_slv_awready;
  logic [31:0] o_slv_wdata;   logic [3:0] o_slv_wstrb; logic o_slv_wvalid; logic i_slv_wready;
  logic [1:0]  i_slv_bresp;   logic i_slv_bvalid;  logic o_slv_bready;

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_ifu_araddr(i_ifu_araddr), .i_ifu_arvalid(i_ifu_arvalid), .o_ifu_arready(o_ifu_arready),
    .o_ifu_rdata(o_ifu_rdata), .o_ifu_rresp(o_ifu_rresp), .o_ifu_rvalid(o_ifu_rvalid),
    .i_ifu_rready(i_ifu_rready),
    .i_lsu_araddr(i_lsu_araddr), .i_lsu_arvalid(i_lsu_arvalid), .o_lsu_arready(o_lsu_arready),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_rresp(o_lsu_rresp), .o_lsu_rvalid(o_lsu_rvalid),
    .i_lsu_rready(i_lsu_rready),
    .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awvalid(i_lsu_awvalid), .o_lsu_awready(o_lsu_awready),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb), .i_lsu_wvalid(i_lsu_wvalid),
    .o_lsu_wready(o_lsu_wready),
    .o_lsu_bresp(o_lsu_bresp), .o_lsu_bvalid(o_lsu_bvalid), .i_lsu_bready(i_lsu_bready),
    .o_slv_araddr(o_slv_araddr), .o_slv_arvalid(o_slv_arvalid), .i_slv_arready(i_slv_arready),
    .i_slv_rdata(i_slv_rdata), .i_slv_rresp(i_slv_rresp), .i_slv_rvalid(i_slv_rvalid),
    .o_slv_rready(o_slv_rready),
    .o_slv_awaddr(o_slv_awaddr), .o_slv_awvalid(o_slv_awvalid), .i_slv_awready(i_slv_awready),
    .o_slv_wdata(o_slv_wdata), .o_slv_wstrb(o_slv_wstrb), .o_slv_wvalid(o_slv_wvalid),
    .i_slv_wready(i_slv_wready),
    .i_slv_bresp(i_slv_bresp), .i_slv_bvalid(i_slv_bvalid), .o_slv_bready(o_slv_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no handshake, expected one within %0d cycles", name, BUDGET);
  endtask

  task automatic push(input int src, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.resp = resp;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] ctl, dat;
    ctl = {20'b0, o_ifu_arready, o_ifu_rvalid, o_lsu_arready, o_lsu_rvalid, o_lsu_awready,
           o_lsu_wready, o_lsu_bvalid, o_slv_arvalid, o_slv_rready, o_slv_awvalid,
           o_slv_wvalid, o_slv_bready};
    dat = o_slv_araddr | o_slv_awaddr | o_slv_wdata | o_ifu_rdata | o_lsu_rdata |
          {22'b0, o_slv_wstrb, o_ifu_rresp, o_lsu_rresp, o_lsu_bresp};
    check({name, "_ctl"}, ctl, 32'h0);
    check({name, "_data"}, dat, 32'h0);
  endtask

  function automatic logic ready_of(input int ch);
    case (ch)
      CH_IFU_AR: return o_ifu_arready;
      CH_LSU_AR: return o_lsu_arready;
      CH_LSU_AW: return o_lsu_awready;
      default:   return o_lsu_wready;
    endcase
  endfunction

  task automatic clear_valid(input int ch);
    case (ch)
      CH_IFU_AR: i_ifu_arvalid = 1'b0;
      CH_LSU_AR: i_lsu_arvalid = 1'b0;
      CH_LSU_AW: i_lsu_awvalid = 1'b0;
      default:   i_lsu_wvalid  = 1'b0;
    endcase
  endtask

  // Master side: hold valid until the handshake edge, then release it.
  task automatic master_hold(input int ch);
    logic r;
    logic done = 1'b0;
    int   n    = 0;
    while (!done) begin
      @(negedge clk);
      r = ready_of(ch);
      @(posedge clk); #1;
      n++;
      if (r) begin
        clear_valid(ch);
        done = 1'b1;
      end else if (n > BUDGET) begin
        timeout($sformatf("master_hold_ch%0d", ch));
        clear_valid(ch);
        done = 1'b1;
      end
    end
  endtask

  task automatic slv_ar_accept(output logic [31:0] a);
    logic seen = 1'b0;
    int   n    = 0;
    a = 32'h0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      seen = o_slv_arvalid;
      n++;
    end
    if (!seen) begin
      timeout("slv_ar_wait");
    end else begin
      @(posedge clk); #1;
      i_slv_arready = 1'b1;
      a = o_slv_araddr;
      @(posedge clk); #1;
      i_slv_arready = 1'b0;
    end
  endtask

  task automatic slv_r_respond(input int lat, input logic [31:0] data, input logic [1:0] resp);
    logic hs   = 1'b0;
    int   n    = 0;
    repeat (lat) @(posedge clk);
    #1;
    i_slv_rvalid = 1'b1;
    i_slv_rdata  = data;
    i_slv_rresp  = resp;
    while (!hs && n < BUDGET) begin
      @(negedge clk);
      hs = o_slv_rready;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) timeout("slv_r_wait");
    i_slv_rvalid = 1'b0;
    i_slv_rdata  = 32'h0;
    i_slv_rresp  = 2'b00;
  endtask

  task automatic slv_read(input int lat, input logic [31:0] data, input logic [1:0] resp,
                          output logic [31:0] a);
    slv_ar_accept(a);
    slv_r_respond(lat, data, resp);
  endtask

  // Slave write side: AW and W accepted independently after their own delays.
  task automatic slv_write(input int aw_lat, input int w_lat, input logic [1:0] bresp,
                           output logic [31:0] a, output logic [31:0] d, output logic [3:0] s);
    logic aw_ok = 1'b0;
    logic w_ok  = 1'b0;
    logic hs    = 1'b0;
    int   n     = 0;
    a = 32'h0; d = 32'h0; s = 4'h0;
    fork
      begin : aw_side
        int k = 0;
        logic seen = 1'b0;
        while (!seen && k < BUDGET) begin @(negedge clk); seen = o_slv_awvalid; k++; end
        if (!seen) timeout("slv_aw_wait");
        else begin
          repeat (aw_lat + 1) @(posedge clk);
          #1;
          i_slv_awready = 1'b1;
          a = o_slv_awaddr;
          @(posedge clk); #1;
          i_slv_awready = 1'b0;
          aw_ok = 1'b1;
          @(negedge clk);
          check("wr_awvalid_drop", {31'b0, o_slv_awvalid}, 32'h0);
          check("wr_bready_after_aw", {31'b0, o_slv_bready}, {31'b0, w_ok});
        end
      end
      begin : w_side
        int k = 0;
        logic seen = 1'b0;
        while (!seen && k < BUDGET) begin @(negedge clk); seen = o_slv_wvalid; k++; end
        if (!seen) timeout("slv_w_wait");
        else begin
          repeat (w_lat + 1) @(posedge clk);
          #1;
          i_slv_wready = 1'b1;
          d = o_slv_wdata;
          s = o_slv_wstrb;
          @(posedge clk); #1;
          i_slv_wready = 1'b0;
          w_ok = 1'b1;
          @(negedge clk);
          check("wr_wvalid_drop", {31'b0, o_slv_wvalid}, 32'h0);
          check("wr_bready_after_w", {31'b0, o_slv_bready}, {31'b0, aw_ok});
        end
      end
    join
    @(posedge clk); #1;
    i_slv_bvalid = 1'b1;
    i_slv_bresp  = bresp;
    while (!hs && n < BUDGET) begin
      @(negedge clk);
      hs = o_slv_bready;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) timeout("slv_b_wait");
    i_slv_bvalid = 1'b0;
    i_slv_bresp  = 2'b00;
  endtask

  task automatic observe(input int src, input logic [31:0] data, input logic [1:0] resp,
                         input logic other_rvalid);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got response from source %0d, expected none", src);
    end else begin
      e = exp_q.pop_front();
      check("sb_src", 32'(src), 32'(e.src));
      if (src != SRC_LSU_B) check("sb_rdata", data, e.data);
      check("sb_resp", {30'b0, resp}, {30'b0, e.resp});
      check("sb_other_rvalid", {31'b0, other_rvalid}, 32'h0);
    end
  endtask

  // Monitor: compares every response handshake against the scoreboard queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_ifu_rvalid && i_ifu_rready) observe(SRC_IFU_R, o_ifu_rdata, o_ifu_rresp, o_lsu_rvalid);
        if (o_lsu_rvalid && i_lsu_rready) observe(SRC_LSU_R, o_lsu_rdata, o_lsu_rresp, o_ifu_rvalid);
        if (o_lsu_bvalid && i_lsu_bready) observe(SRC_LSU_B, 32'h0, o_lsu_bresp,
                                                  o_lsu_rvalid | o_ifu_rvalid);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a, d;
    logic [3:0]  s;
    rst = 1'b1;
    i_ifu_araddr = 32'h8000_0040; i_ifu_arvalid = 1'b1; i_ifu_rready = 1'b1;
    i_lsu_araddr = 32'h8000_0200; i_lsu_arvalid = 1'b1; i_lsu_rready = 1'b1;
    i_lsu_awaddr = 32'h0; i_lsu_awvalid = 1'b0; i_lsu_wdata = 32'h0; i_lsu_wstrb = 4'h0;
    i_lsu_wvalid = 1'b0; i_lsu_bready = 1'b1;
    i_slv_arready = 1'b0; i_slv_rdata = 32'h0; i_slv_rresp = 2'b00; i_slv_rvalid = 1'b0;
    i_slv_awready = 1'b0; i_slv_wready = 1'b0; i_slv_bresp = 2'b00; i_slv_bvalid = 1'b0;

    // Reset state, with both masters already requesting.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset: LSU, IFU, LSU, IFU, LSU, IFU.
    for (int i = 0; i < 6; i++) begin
      push((i % 2 == 0) ? SRC_LSU_R : SRC_IFU_R, 32'hA000_0000 + 32'(i), 2'b00);
      slv_read(1, 32'hA000_0000 + 32'(i), 2'b00, a);
      check("alt_araddr", a, (i % 2 == 0) ? 32'h8000_0200 : 32'h8000_0040);
    end
    i_ifu_arvalid = 1'b0;
    i_lsu_arvalid = 1'b0;

    // IFU-only read; AR is forwarded one cycle after the request.
    @(posedge clk); #1;
    i_ifu_araddr  = 32'h8000_0000;
    i_ifu_arvalid = 1'b1;
    push(SRC_IFU_R, 32'h0000_0413, 2'b00);
    @(negedge clk);
    check("ifu_no_fwd_idle", {31'b0, o_slv_arvalid}, 32'h0);
    @(negedge clk);
    check("ifu_ar_fwd", {31'b0, o_slv_arvalid}, 32'h1);
    check("ifu_lsu_quiet", {27'b0, o_lsu_arready, o_lsu_rvalid, o_lsu_awready,
                            o_lsu_wready, o_lsu_bvalid}, 32'h0);
    fork
      master_hold(CH_IFU_AR);
      slv_read(2, 32'h0000_0413, 2'b00, a);
    join
    check("ifu_araddr", a, 32'h8000_0000);

    // LSU write: W accepted three cycles before AW.
    @(posedge clk); #1;
    i_lsu_awaddr = 32'h8000_0100; i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_wstrb = 4'b1111;
    i_lsu_awvalid = 1'b1; i_lsu_wvalid = 1'b1;
    push(SRC_LSU_B, 32'h0, 2'b00);
    fork
      master_hold(CH_LSU_AW);
      master_hold(CH_LSU_W);
      slv_write(3, 0, 2'b00, a, d, s);
    join
    check("wr_awaddr", a, 32'h8000_0100);
    check("wr_wdata", d, 32'hDEAD_BEEF);
    check("wr_wstrb", {28'b0, s}, 32'hF);

    // LSU write and read requested together: write goes first.
    @(posedge clk); #1;
    i_lsu_awaddr = 32'h8000_0104; i_lsu_wdata = 32'h1234_5678; i_lsu_wstrb = 4'b0011;
    i_lsu_awvalid = 1'b1; i_lsu_wvalid = 1'b1;
    i_lsu_araddr = 32'h8000_0300; i_lsu_arvalid = 1'b1;
    push(SRC_LSU_B, 32'h0, 2'b00);
    push(SRC_LSU_R, 32'hCAFE_F00D, 2'b00);
    fork
      master_hold(CH_LSU_AW);
      master_hold(CH_LSU_W);
      master_hold(CH_LSU_AR);
      begin
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        slv_write(0, 0, 2'b00, wa, wd, ws);
        check("wr2_awaddr", wa, 32'h8000_0104);
        check("wr2_wdata", wd, 32'h1234_5678);
        check("wr2_wstrb", {28'b0, ws}, 32'h3);
      end
      begin
        logic [31:0] ra;
        slv_read(1, 32'hCAFE_F00D, 2'b00, ra);
        check("rd2_araddr", ra, 32'h8000_0300);
      end
    join

    // Asynchronous reset while the slave is stalling the R channel.
    @(posedge clk); #1;
    i_ifu_araddr = 32'h8000_0080; i_ifu_arvalid = 1'b1;
    fork
      master_hold(CH_IFU_AR);
      slv_ar_accept(a);
    join
    @(negedge clk);
    check("rsp_rready_before_rst", {31'b0, o_slv_rready}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    i_ifu_araddr = 32'h8000_0004; i_ifu_arvalid = 1'b1;
    push(SRC_IFU_R, 32'h0000_0513, 2'b00);
    fork
      master_hold(CH_IFU_AR);
      slv_read(2, 32'h0000_0513, 2'b00, a);
    join
    check("post_rst_araddr", a, 32'h8000_0004);

    // Error response passes through; the next request is still served.
    @(posedge clk); #1;
    i_lsu_araddr = 32'h8000_0400; i_lsu_arvalid = 1'b1;
    push(SRC_LSU_R, 32'hBAD0_0000, 2'b10);
    fork
      master_hold(CH_LSU_AR);
      slv_read(1, 32'hBAD0_0000, 2'b10, a);
    join
    @(posedge clk); #1;
    i_ifu_araddr = 32'h8000_0008; i_ifu_arvalid = 1'b1;
    push(SRC_IFU_R, 32'h0000_0613, 2'b00);
    fork
      master_hold(CH_IFU_AR);
      slv_read(1, 32'h0000_0613, 2'b00, a);
    join
    check("after_err_araddr", a, 32'h8000_0008);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
